fir_job_offloader: RTL and testbench

- Bus-initiator counterpart of the FIR accelerator's peripheral register slave.
- Accepts a FIR job descriptor over a valid/ready port and acquires a job context on the HWPE through the hwpe_ctrl peripheral protocol.
- Programs the four FIR job registers, triggers the job, waits for the completion event, then reports done with the acquired job ID.
- Sits in the cluster-side test harness and DMA-less offload path, between a job source and the accelerator's periph slave port.

---
 rtl/fir_job_offloader.sv | 177 +++++++++++++++++
 tb/tb_fir_job_offloader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_job_offloader.sv
// Bus-initiator that offloads one FIR job descriptor to the accelerator's periph slave:
// acquire a context, program the job registers, trigger, and wait for the completion event.
module fir_job_offloader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ID_WIDTH  = 10,
    parameter int unsigned MY_ID     = 1,
    parameter int unsigned RETRY_GAP = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                job_valid_i,
    output logic                job_ready_o,
    input  logic [31:0]         job_x_addr_i,
    input  logic [31:0]         job_h_addr_i,
    input  logic [31:0]         job_y_addr_i,
    input  logic [5:0]          job_shift_i,
    input  logic [15:0]         job_length_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [7:0]          job_id_o,
    input  logic                evt_i,
    output logic                periph_req_o,
    input  logic                periph_gnt_i,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_r_valid_i,
    input  logic [31:0]         periph_r_data_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i
);

    localparam int unsigned GW = (RETRY_GAP < 2) ? 1 : $clog2(RETRY_GAP + 1);
    localparam logic [ID_WIDTH-1:0] MY_ID_W = ID_WIDTH'(MY_ID);

    typedef enum logic [2:0] {
        S_IDLE, S_ACQ_REQ, S_ACQ_WAIT, S_BACKOFF,
        S_WR_REGS, S_TRIGGER, S_WAIT_EVT, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   x_q, x_d, h_q, h_d, y_q, y_d;
    logic [5:0]    shift_q, shift_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    id_q, id_d;
    logic [1:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rsp_ok;

    assign rsp_ok = periph_r_valid_i && (periph_r_id_i == MY_ID_W);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            h_q     <= '0;
            y_q     <= '0;
            shift_q <= '0;
            len_q   <= '0;
            id_q    <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            h_q     <= h_d;
            y_q     <= y_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        h_d     = h_q;
        y_d     = y_q;
        shift_d = shift_q;
        len_d   = len_q;
        id_d    = id_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (job_valid_i) begin
                    x_d     = job_x_addr_i;
                    h_d     = job_h_addr_i;
                    y_d     = job_y_addr_i;
                    shift_d = job_shift_i;
                    len_d   = job_length_i;
                    state_d = S_ACQ_REQ;
                end
            end
            S_ACQ_REQ: begin
                if (periph_gnt_i) state_d = S_ACQ_WAIT;
            end
            S_ACQ_WAIT: begin
                if (rsp_ok) begin
                    if (periph_r_data_i[31]) begin
                        gap_d   = GW'(RETRY_GAP);
                        state_d = S_BACKOFF;
                    end else begin
                        id_d    = periph_r_data_i[7:0];
                        idx_d   = '0;
                        state_d = S_WR_REGS;
                    end
                end
            end
            S_BACKOFF: begin
                // Leaving on the count of 1 keeps req low for exactly RETRY_GAP cycles.
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) state_d = S_ACQ_REQ;
            end
            S_WR_REGS: begin
                if (periph_gnt_i) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                if (periph_gnt_i) state_d = S_WAIT_EVT;
            end
            S_WAIT_EVT: begin
                if (evt_i) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        job_ready_o   = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        periph_req_o  = 1'b0;
        periph_add_o  = '0;
        periph_wen_o  = 1'b0;
        periph_data_o = '0;
        unique case (state_q)
            S_IDLE: job_ready_o = 1'b1;
            S_ACQ_REQ: begin
                busy_o       = 1'b1;
                periph_req_o = 1'b1;
                periph_wen_o = 1'b1;
                periph_add_o = BASE_ADDR + 32'h04;
            end
            S_WR_REGS: begin
                busy_o       = 1'b1;
                periph_req_o = 1'b1;
                periph_add_o = BASE_ADDR + 32'h40 + {28'd0, idx_q, 2'b00};
                unique case (idx_q)
                    2'd0: periph_data_o = x_q;
                    2'd1: periph_data_o = h_q;
                    2'd2: periph_data_o = y_q;
                    2'd3: periph_data_o = {len_q, 10'd0, shift_q};
                    default: periph_data_o = '0;
                endcase
            end
            S_TRIGGER: begin
                busy_o       = 1'b1;
                periph_req_o = 1'b1;
                periph_add_o = BASE_ADDR;
            end
            S_DONE: done_o = 1'b1;
            default: busy_o = 1'b1;
        endcase
    end

    assign job_id_o    = id_q;
    assign periph_be_o = 4'hF;
    assign periph_id_o = MY_ID_W;

endmodule

// File: tb/tb_fir_job_offloader.sv
// Table-driven bench for fir_job_offloader: a bus/event responder drives each job row
// and checks every request, the acquire retry gap, latency and completion signalling.
module tb_fir_job_offloader;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid, job_ready;
    logic [31:0] jx, jh, jy;
    logic [5:0]  jsh;
    logic [15:0] jlen;
    logic        busy, done, evt;
    logic [7:0]  job_id;
    logic        req, gnt, wen, rv;
    logic [31:0] add, wdata, rdata;
    logic [3:0]  be;
    logic [9:0]  pid, rid;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_prev_id;

    always #5 clk = ~clk;

    fir_job_offloader #(
        .BASE_ADDR(BASE),
        .ID_WIDTH (10),
        .MY_ID    (1),
        .RETRY_GAP(GAP)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .job_valid_i     (job_valid),
        .job_ready_o     (job_ready),
        .job_x_addr_i    (jx),
        .job_h_addr_i    (jh),
        .job_y_addr_i    (jy),
        .job_shift_i     (jsh),
        .job_length_i    (jlen),
        .busy_o          (busy),
        .done_o          (done),
        .job_id_o        (job_id),
        .evt_i           (evt),
        .periph_req_o    (req),
        .periph_gnt_i    (gnt),
        .periph_add_o    (add),
        .periph_wen_o    (wen),
        .periph_be_o     (be),
        .periph_data_o   (wdata),
        .periph_id_o     (pid),
        .periph_r_valid_i(rv),
        .periph_r_data_i (rdata),
        .periph_r_id_i   (rid)
    );

    typedef struct {
        logic [31:0] x, h, y;
        logic [5:0]  sh;
        logic [15:0] len;
        int          busy_n;
        logic [31:0] acq_data;
        int          stall_idx;
        int          stall_n;
        bit          foreign;
        int          evt_delay;
        logic [7:0]  exp_id;
        logic [31:0] exp_sl;
        int          exp_acq;
        int          exp_lat;
    } job_t;

    job_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_desc(input int k);
        jx   = tbl[k].x;
        jh   = tbl[k].h;
        jy   = tbl[k].y;
        jsh  = tbl[k].sh;
        jlen = tbl[k].len;
    endtask

    task automatic do_reset_abort();
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(job_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_jobid", 32'(job_id), 32'd0);
        gnt = 1'b0; rv = 1'b0; evt = 1'b0; job_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_prev_id = 8'd0;
    endtask

    // abort: 0 none, 1 reset in WAIT_EVT, 2 reset with req high on the Y_ADDR write
    task automatic run_job(input int k, input int abort, input bit hold_next, input bit spur);
        job_t j;
        logic [31:0] ea[5];
        logic [31:0] ed[5];
        int wr_seen = 0, acq_n = 0, busy_left, stall_cnt = 0, gap = 0, trig_it = -1;
        bit pending = 0, foreign_done = 0, acq_ok = 0, counting = 0, evt_q = 0, got_done = 0;
        j = tbl[k];
        busy_left = j.busy_n;
        ea[0] = BASE + 32'h40; ed[0] = j.x;
        ea[1] = BASE + 32'h44; ed[1] = j.h;
        ea[2] = BASE + 32'h48; ed[2] = j.y;
        ea[3] = BASE + 32'h4C; ed[3] = j.exp_sl;
        ea[4] = BASE;          ed[4] = 32'h0;

        drive_desc(k);
        job_valid = 1'b1;
        chk("ready_at_accept", 32'(job_ready), 32'd1);
        @(negedge clk);
        if (hold_next) drive_desc(k + 1);
        else begin
            job_valid = 1'b0;
            jx = 32'hFFFF_FFFF; jh = 32'hEEEE_EEEE; jy = 32'hDDDD_DDDD; jsh = 6'h2A; jlen = 16'h5555;
        end

        for (int it = 0; it < 300; it++) begin
            chk("done_timing", 32'(done), 32'(evt_q));
            if (done) begin
                chk("done_busy", 32'(busy), 32'd0);
                chk("job_id", 32'(job_id), 32'(j.exp_id));
                chk("acq_reads", 32'(acq_n), 32'(j.exp_acq));
                got_done = 1;
                break;
            end
            chk("busy", 32'(busy), 32'd1);
            chk("ready_busy", 32'(job_ready), 32'd0);
            if (it == 0) chk("job_id_held", 32'(job_id), 32'(exp_prev_id));
            gnt = 1'b0; rv = 1'b0; rid = 10'd1; rdata = 32'h0; evt = 1'b0; evt_q = 0;

            if (trig_it >= 0) begin
                chk("req_wait_evt", 32'(req), 32'd0);
                if (abort == 1) begin
                    do_reset_abort();
                    return;
                end
                if (it - trig_it == 1 + j.evt_delay) begin
                    evt = 1'b1;
                    evt_q = 1;
                end
            end

            if (pending) begin
                rv = 1'b1;
                if (j.foreign && !foreign_done) begin
                    rid = 10'd3;
                    rdata = 32'h0;
                    foreign_done = 1;
                end else begin
                    if (busy_left > 0) begin
                        rdata = 32'hFFFF_FFFF;
                        busy_left--;
                        counting = 1;
                        gap = 0;
                    end else begin
                        rdata = j.acq_data;
                        acq_ok = 1;
                    end
                    pending = 0;
                end
            end else if (counting && !req) gap++;

            if (req) begin
                if (counting) begin
                    chk("retry_gap", 32'(gap), 32'(GAP));
                    counting = 0;
                end
                if (wen) begin
                    chk("acq_addr", add, BASE + 32'h4);
                    chk("acq_before_writes", 32'(acq_ok), 32'd0);
                    gnt = 1'b1;
                    acq_n++;
                    pending = 1;
                end else begin
                    chk("write_after_acq", 32'(acq_ok), 32'd1);
                    if (wr_seen > 4) chk("extra_write", 32'(wr_seen), 32'd4);
                    else begin
                        chk("wr_addr", add, ea[wr_seen]);
                        chk("wr_data", wdata, ed[wr_seen]);
                    end
                    if (abort == 2 && wr_seen == 2) begin
                        do_reset_abort();
                        return;
                    end
                    if (spur && wr_seen == 1) evt = 1'b1;
                    if (wr_seen == j.stall_idx && stall_cnt < j.stall_n) stall_cnt++;
                    else begin
                        gnt = 1'b1;
                        wr_seen++;
                        if (wr_seen == 5) begin
                            trig_it = it;
                            if (j.exp_lat != 0) chk("trigger_latency", 32'(it + 1), 32'(j.exp_lat));
                        end
                    end
                end
            end
            @(negedge clk);
        end
        gnt = 1'b0; rv = 1'b0; evt = 1'b0;
        if (!got_done) chk("job_timeout", 32'd0, 32'd1);
        exp_prev_id = j.exp_id;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ready_after_done", 32'(job_ready), 32'd1);
    endtask

    initial begin
        //        x             h             y             sh     len        busy acq            stall   fgn evtd id     sl             acq lat
        tbl[0] = '{32'h100,      32'h200,      32'h300,      6'd13, 16'd64,    0, 32'h0000_0002, -1, 0, 0,  0, 8'h02, 32'h0040_000D, 1, 7};
        tbl[1] = '{32'h1111_0000,32'h2222_0004,32'h3333_0008,6'd0,  16'd1,     2, 32'h0000_0005, -1, 0, 0,  3, 8'h05, 32'h0001_0000, 3, 0};
        tbl[2] = '{32'h100,      32'h200,      32'h300,      6'd63, 16'hFFFF,  0, 32'h7FFF_FF0A,  1, 5, 0,  1, 8'h0A, 32'hFFFF_003F, 1, 0};
        tbl[3] = '{32'hDEAD_BEEC,32'h0000_0010,32'h8000_0000,6'd5,  16'h0100,  0, 32'h0000_0007, -1, 0, 1,  0, 8'h07, 32'h0100_0005, 1, 0};
        tbl[4] = '{32'h4000_0000,32'h4000_1000,32'h4000_2000,6'd1,  16'd2,     0, 32'h0000_0033, -1, 0, 0,  2, 8'h33, 32'h0002_0001, 1, 7};
        tbl[5] = '{32'h0A0,      32'h0B0,      32'h0C0,      6'd7,  16'h0010,  0, 32'h0000_0011, -1, 0, 0,  0, 8'h11, 32'h0010_0007, 1, 7};
        tbl[6] = '{32'hC0FF_EE00,32'h1234_5678,32'h0BAD_F00C,6'h20, 16'h8000,  0, 32'h0000_00FE, -1, 0, 0,  1, 8'hFE, 32'h8000_0020, 1, 7};

        rst = 1'b1; job_valid = 1'b0; evt = 1'b0; gnt = 1'b0; rv = 1'b0;
        rdata = 32'h0; rid = 10'd1; exp_prev_id = 8'd0;
        jx = '0; jh = '0; jy = '0; jsh = '0; jlen = '0;
        @(negedge clk);
        chk("reset_ready", 32'(job_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_req", 32'(req), 32'd0);
        chk("reset_jobid", 32'(job_id), 32'd0);
        chk("be_const", 32'(be), 32'hF);
        chk("id_const", 32'(pid), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 4; k++) run_job(k, 0, 0, 0);
        run_job(0, 1, 0, 0);
        run_job(4, 0, 0, 0);
        run_job(2, 2, 0, 0);
        run_job(4, 0, 0, 0);
        run_job(5, 0, 1, 1);
        run_job(6, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
